// File: rtl/reduceron_console_tx.sv
// reduceron_console_tx
// Merges Reduceron console character writes and the final result line into a
// single ordered byte stream for the JTAG UART transmit side.
//
// Ports:
//   clock, reset   - system clock, asynchronous active-high reset
//   io_write       - core IO write strobe (one-cycle pulse)
//   io_addr        - core IO address; CHAR_ADDR selects a console write
//   io_wdata       - core IO write data, [7:0] is the character
//   finish, result - one-cycle finish pulse with the result value
//   tx_data        - byte to UART
//   tx_valid       - tx_data valid
//   tx_ready       - UART accepts the byte
//   overflow       - sticky: character dropped or finish ignored
//   busy           - anything still queued, formatting or being presented
//   fifo_level     - current character FIFO occupancy
module reduceron_console_tx #(
    parameter int FIFO_LOG2 = 4,
    parameter int CHAR_ADDR = 0,
    parameter int RESULT_W  = 18,
    parameter int DIGITS    = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_write,
    input  logic [14:0]          io_addr,
    input  logic [14:0]          io_wdata,
    input  logic                 finish,
    input  logic [RESULT_W-1:0]  result,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 overflow,
    output logic                 busy,
    output logic [FIFO_LOG2:0]   fifo_level
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int HW    = 4 * DIGITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DIGIT = 2'd1;
    localparam logic [1:0] S_CR    = 2'd2;
    localparam logic [1:0] S_LF    = 2'd3;

    logic [7:0]           mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_LOG2:0]   count, count_next, drain_left;
    logic                 pending;
    logic [1:0]           state;
    logic [IW-1:0]        idx;
    logic [HW-1:0]        res_q;

    logic       push_req, push_ok, full, pop, load;
    logic       fmt_load, fmt_start, fin_ok;
    logic       ld_valid;
    logic [7:0] ld_byte, fmt_byte;
    logic       unused_wdata;

    assign unused_wdata = ^io_wdata[14:8];

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
    endfunction

    always_comb begin
        push_req  = io_write && (io_addr == 15'(CHAR_ADDR));
        full      = (count == (FIFO_LOG2 + 1)'(DEPTH));
        load      = !tx_valid || tx_ready;
        fin_ok    = finish && !pending && (state == S_IDLE);
        pop       = 1'b0;
        fmt_load  = 1'b0;
        fmt_start = 1'b0;
        ld_valid  = 1'b0;
        ld_byte   = 8'h00;

        case (state)
            S_DIGIT: fmt_byte = hex(res_q[idx*4 +: 4]);
            S_CR:    fmt_byte = 8'h0D;
            default: fmt_byte = 8'h0A;
        endcase

        // Priority: an active line finishes first; a pending result first
        // drains the characters that were queued ahead of it.
        if (load) begin
            if (state != S_IDLE) begin
                fmt_load = 1'b1;
                ld_valid = 1'b1;
                ld_byte  = fmt_byte;
            end else if (pending && drain_left != '0) begin
                pop      = 1'b1;
                ld_valid = 1'b1;
                ld_byte  = mem[rd_ptr];
            end else if (pending) begin
                fmt_start = 1'b1;
                ld_valid  = 1'b1;
                ld_byte   = hex(res_q[HW-1 -: 4]);
            end else if (count != '0) begin
                pop      = 1'b1;
                ld_valid = 1'b1;
                ld_byte  = mem[rd_ptr];
            end
        end

        // A pop frees a slot in the same cycle, so push at full is fine then.
        push_ok    = push_req && (!full || pop);
        count_next = count + {{FIFO_LOG2{1'b0}}, push_ok} - {{FIFO_LOG2{1'b0}}, pop};
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= io_wdata[7:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drain_left <= '0;
            pending    <= 1'b0;
            state      <= S_IDLE;
            idx        <= '0;
            res_q      <= '0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;

            if (load) begin
                tx_valid <= ld_valid;
                if (ld_valid) tx_data <= ld_byte;
            end

            if ((push_req && !push_ok) || (finish && !fin_ok))
                overflow <= 1'b1;

            // drain_left counts what is left in the FIFO after this edge,
            // so a same-cycle character write is emitted before the result.
            if (fin_ok) begin
                pending    <= 1'b1;
                res_q      <= HW'(result);
                drain_left <= count_next;
            end else if (pending && pop) begin
                drain_left <= drain_left - 1'b1;
            end

            if (fmt_start) begin
                if (DIGITS > 1) begin
                    state <= S_DIGIT;
                    idx   <= IW'((DIGITS > 1) ? DIGITS - 2 : 0);
                end else begin
                    state <= S_CR;
                end
            end else if (fmt_load) begin
                case (state)
                    S_DIGIT: begin
                        if (idx == '0) state <= S_CR;
                        else           idx   <= idx - 1'b1;
                    end
                    S_CR:    state <= S_LF;
                    default: begin
                        state   <= S_IDLE;
                        pending <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy       = pending || (state != S_IDLE) || (count != '0) || tx_valid;
    assign fifo_level = count;

endmodule

// File: tb/tb_reduceron_console_tx.sv
module tb_reduceron_console_tx;
    localparam int DIGITS = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_write = 1'b0;
    logic [14:0] io_addr = '0;
    logic [14:0] io_wdata = '0;
    logic        finish = 1'b0;
    logic [17:0] result = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        overflow;
    logic        busy;
    logic [4:0]  fifo_level;

    int vecs = 0;
    int errs = 0;

    logic [7:0] got[$];
    logic [7:0] exp[$];

    reduceron_console_tx dut (
        .clock(clock), .reset(reset), .io_write(io_write), .io_addr(io_addr),
        .io_wdata(io_wdata), .finish(finish), .result(result), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .overflow(overflow), .busy(busy),
        .fifo_level(fifo_level)
    );

    always #5 clock = ~clock;

    // Capture every handshake; inputs only change just after posedge,
    // so the negedge view holds through the transferring edge.
    always @(negedge clock) begin
        if (!reset && tx_valid && tx_ready) got.push_back(tx_data);
    end

    // Reference model: expected output is simply program order.
    function automatic void m_char(input logic [7:0] c);
        exp.push_back(c);
    endfunction

    function automatic void m_finish(input logic [17:0] v);
        for (int d = DIGITS - 1; d >= 0; d--) begin
            int n;
            n = (int'(v) >> (4 * d)) & 15;
            exp.push_back(n < 10 ? 8'(48 + n) : 8'(65 + n - 10));
        end
        exp.push_back(8'h0D);
        exp.push_back(8'h0A);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        io_write = 1'b0; finish = 1'b0; tx_ready = 1'b0;
        io_addr = '0; io_wdata = '0; result = '0;
        repeat (2) step();
        reset = 1'b0;
        got.delete();
        exp.delete();
        step();
    endtask

    task automatic wait_drain(input string name);
        int n;
        tx_ready = 1'b1;
        n = 0;
        while (busy && n < 2000) begin
            step();
            n++;
        end
        vecs++;
        if (busy) begin
            errs++;
            $display("FAIL %s drain timeout busy=%0b", name, busy);
        end
        step();
    endtask

    task automatic write_char(input logic [14:0] a, input logic [7:0] c);
        io_write = 1'b1; io_addr = a; io_wdata = {7'h55, c};
        step();
        io_write = 1'b0;
    endtask

    task automatic do_finish(input logic [17:0] v);
        finish = 1'b1; result = v;
        step();
        finish = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        vecs += 5;
        if (tx_valid !== 1'b0)   begin errs++; $display("FAIL reset tx_valid got %b exp 0", tx_valid); end
        if (tx_data !== 8'h00)   begin errs++; $display("FAIL reset tx_data got %h exp 00", tx_data); end
        if (overflow !== 1'b0)   begin errs++; $display("FAIL reset overflow got %b exp 0", overflow); end
        if (busy !== 1'b0)       begin errs++; $display("FAIL reset busy got %b exp 0", busy); end
        if (fifo_level !== 5'd0) begin errs++; $display("FAIL reset fifo_level got %0d exp 0", fifo_level); end
        do_reset();
    endtask

    task automatic test_latency();
        do_reset();
        tx_ready = 1'b1;
        io_write = 1'b1; io_addr = 15'd0; io_wdata = 15'h0048;
        m_char(8'h48);
        step();
        vecs++;
        if (tx_valid !== 1'b0) begin errs++; $display("FAIL latency edge1 tx_valid got %b exp 0", tx_valid); end
        io_wdata = 15'h0069;
        m_char(8'h69);
        step();
        io_write = 1'b0;
        vecs += 2;
        if (tx_valid !== 1'b1) begin errs++; $display("FAIL latency edge2 tx_valid got %b exp 1", tx_valid); end
        if (tx_data !== 8'h48) begin errs++; $display("FAIL latency edge2 tx_data got %h exp 48", tx_data); end
        wait_drain("latency");
        vecs++;
        if (got.size() != exp.size()) begin errs++; $display("FAIL latency count got %0d exp %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            vecs++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                errs++; $display("FAIL latency byte%0d got %h exp %h", i, i < got.size() ? got[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_result();
        do_reset();
        tx_ready = 1'b1;
        do_finish(18'h2A5F3);
        m_finish(18'h2A5F3);
        wait_drain("result");
        vecs += 3;
        if (busy !== 1'b0) begin errs++; $display("FAIL result busy got %b exp 0", busy); end
        if (overflow !== 1'b0) begin errs++; $display("FAIL result overflow got %b exp 0", overflow); end
        if (got.size() != exp.size()) begin errs++; $display("FAIL result count got %0d exp %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            vecs++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                errs++; $display("FAIL result byte%0d got %h exp %h", i, i < got.size() ? got[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_order();
        do_reset();
        tx_ready = 1'b0;
        write_char(15'd0, "a"); m_char("a");
        write_char(15'd0, "b"); m_char("b");
        write_char(15'd0, "c"); m_char("c");
        do_finish(18'h00001);   m_finish(18'h00001);
        write_char(15'd0, "z"); m_char("z");
        write_char(15'd3, "q");
        repeat (3) step();
        wait_drain("order");
        vecs++;
        if (got.size() != exp.size()) begin errs++; $display("FAIL order count got %0d exp %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            vecs++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                errs++; $display("FAIL order byte%0d got %h exp %h", i, i < got.size() ? got[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            write_char(15'd0, 8'(i));
            if (i < 17) m_char(8'(i));
        end
        vecs += 4;
        if (overflow !== 1'b1)    begin errs++; $display("FAIL overflow flag got %b exp 1", overflow); end
        if (fifo_level !== 5'd16) begin errs++; $display("FAIL overflow level got %0d exp 16", fifo_level); end
        if (tx_valid !== 1'b1)    begin errs++; $display("FAIL overflow tx_valid got %b exp 1", tx_valid); end
        if (tx_data !== 8'h00)    begin errs++; $display("FAIL overflow tx_data got %h exp 00", tx_data); end
        wait_drain("overflow");
        vecs++;
        if (got.size() != exp.size()) begin errs++; $display("FAIL overflow count got %0d exp %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            vecs++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                errs++; $display("FAIL overflow byte%0d got %h exp %h", i, i < got.size() ? got[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_double_finish();
        do_reset();
        tx_ready = 1'b1;
        do_finish(18'h3BEEF); m_finish(18'h3BEEF);
        step();
        vecs++;
        if (overflow !== 1'b0) begin errs++; $display("FAIL dblfin early overflow got %b exp 0", overflow); end
        do_finish(18'h12345);
        vecs++;
        if (overflow !== 1'b1) begin errs++; $display("FAIL dblfin overflow got %b exp 1", overflow); end
        wait_drain("dblfin");
        vecs++;
        if (got.size() != exp.size()) begin errs++; $display("FAIL dblfin count got %0d exp %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            vecs++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                errs++; $display("FAIL dblfin byte%0d got %h exp %h", i, i < got.size() ? got[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tx_ready = 1'b1;
        write_char(15'd0, "x");
        do_finish(18'(($urandom % 'h3FFFF) + 1));
        for (int i = 0; i < 4; i++) begin
            tx_ready = 1'($urandom);
            step();
        end
        #2 reset = 1'b1;
        #1;
        vecs += 5;
        if (tx_valid !== 1'b0)   begin errs++; $display("FAIL midreset tx_valid got %b exp 0", tx_valid); end
        if (tx_data !== 8'h00)   begin errs++; $display("FAIL midreset tx_data got %h exp 00", tx_data); end
        if (busy !== 1'b0)       begin errs++; $display("FAIL midreset busy got %b exp 0", busy); end
        if (fifo_level !== 5'd0) begin errs++; $display("FAIL midreset fifo_level got %0d exp 0", fifo_level); end
        if (overflow !== 1'b0)   begin errs++; $display("FAIL midreset overflow got %b exp 0", overflow); end
        step();
        reset = 1'b0;
        got.delete(); exp.delete();
        tx_ready = 1'b1;
        step();
        write_char(15'd0, 8'h5A); m_char(8'h5A);
        wait_drain("midreset");
        vecs++;
        if (got.size() != exp.size()) begin errs++; $display("FAIL midreset count got %0d exp %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            vecs++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                errs++; $display("FAIL midreset byte%0d got %h exp %h", i, i < got.size() ? got[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_random();
        int line_end;
        do_reset();
        line_end = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tx_ready = ($urandom_range(0, 9) < 7);
            io_write = 1'b0;
            finish = 1'b0;
            // Keep outstanding work below the FIFO depth so nothing is dropped.
            if ((exp.size() - got.size()) < 15 && $urandom_range(0, 9) < 4) begin
                io_write = 1'b1;
                io_wdata = 15'($urandom);
                io_addr = ($urandom_range(0, 9) < 2) ? 15'($urandom_range(1, 32767)) : 15'd0;
                if (io_addr == 15'd0) m_char(io_wdata[7:0]);
            end
            if (got.size() >= line_end && $urandom_range(0, 19) == 0) begin
                finish = 1'b1;
                result = 18'($urandom);
                m_finish(result);
                line_end = exp.size();
            end
            step();
        end
        io_write = 1'b0;
        finish = 1'b0;
        wait_drain("random");
        vecs += 2;
        if (overflow !== 1'b0) begin errs++; $display("FAIL random overflow got %b exp 0", overflow); end
        if (got.size() != exp.size()) begin errs++; $display("FAIL random count got %0d exp %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            vecs++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                errs++; $display("FAIL random byte%0d got %h exp %h", i, i < got.size() ? got[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_result();
        test_order();
        test_overflow();
        test_double_finish();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
